// File: rtl/elastic_pipeline.sv
// Valid/ready register pipeline of N stages with bubble collapse, synchronous
// flush and a registered occupancy count.
module elastic_pipeline #(
  parameter int PIPELINE_STAGES = 1,
  parameter int PIPELINE_WIDTH  = 1,
  localparam int CW = $clog2(PIPELINE_STAGES + 1)
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      flush_in,
  input  logic                      s_valid_in,
  input  logic [PIPELINE_WIDTH-1:0] s_data_in,
  output logic                      s_ready_out,
  output logic                      m_valid_out,
  output logic [PIPELINE_WIDTH-1:0] m_data_out,
  input  logic                      m_ready_in,
  output logic [CW-1:0]             count_out
);

  localparam int N = PIPELINE_STAGES;
  localparam int W = PIPELINE_WIDTH;

  // Handshake: a beat moves across an interface on a rising edge exactly when
  // valid and ready are both high there; valid never depends on ready, while
  // ready may depend combinationally on the downstream ready.
  logic [N-1:0] vld;
  logic [W-1:0] dat [N];
  logic [N-1:0] rdy;
  logic         up;
  logic         down;

  // rdy[i]: some stage at or after i is empty, or the consumer takes a beat.
  always_comb begin : ready_chain
    logic acc;
    acc = m_ready_in;
    rdy = '0;
    for (int i = N - 1; i >= 0; i--) begin
      acc    = acc || !vld[i];
      rdy[i] = acc;
    end
  end

  assign s_ready_out = rdy[0] && !flush_in;
  assign m_valid_out = vld[N-1];
  assign m_data_out  = dat[N-1];
  assign up          = s_valid_in && s_ready_out;
  assign down        = m_valid_out && m_ready_in;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      vld[0] <= 1'b0;
      dat[0] <= '0;
    end else if (flush_in) begin
      vld[0] <= 1'b0;
    end else if (rdy[0]) begin
      vld[0] <= s_valid_in;
      if (s_valid_in) dat[0] <= s_data_in;
    end
  end

  for (genvar g = 1; g < N; g++) begin : g_stage
    always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
        vld[g] <= 1'b0;
        dat[g] <= '0;
      end else if (flush_in) begin
        vld[g] <= 1'b0;
      end else if (rdy[g]) begin
        vld[g] <= vld[g-1];
        if (vld[g-1]) dat[g] <= dat[g-1];
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      count_out <= '0;
    end else if (flush_in) begin
      count_out <= '0;
    end else begin
      count_out <= count_out + CW'(up) - CW'(down);
    end
  end

endmodule

// File: tb/tb_elastic_pipeline.sv
// Self-checking bench for elastic_pipeline: directed steps on an N=4 instance,
// then randomised traffic on N=1 and N=5 instances against a queue model.
module tb_elastic_pipeline;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic [7:0] exp_q[$];
  int tests = 0;
  int fails = 0;

  // N = 4
  logic       f4, sv4, sr4, mv4, mr4;
  logic [7:0] sd4, md4;
  logic [2:0] cnt4;
  // N = 1
  logic       f1, sv1, sr1, mv1, mr1;
  logic [7:0] sd1, md1;
  logic [0:0] cnt1;
  // N = 5
  logic       f5, sv5, sr5, mv5, mr5;
  logic [7:0] sd5, md5;
  logic [2:0] cnt5;

  elastic_pipeline #(.PIPELINE_STAGES(4), .PIPELINE_WIDTH(8)) dut4 (
    .clk_in(clk), .rst_in(rst), .flush_in(f4), .s_valid_in(sv4), .s_data_in(sd4),
    .s_ready_out(sr4), .m_valid_out(mv4), .m_data_out(md4), .m_ready_in(mr4),
    .count_out(cnt4));

  elastic_pipeline #(.PIPELINE_STAGES(1), .PIPELINE_WIDTH(8)) dut1 (
    .clk_in(clk), .rst_in(rst), .flush_in(f1), .s_valid_in(sv1), .s_data_in(sd1),
    .s_ready_out(sr1), .m_valid_out(mv1), .m_data_out(md1), .m_ready_in(mr1),
    .count_out(cnt1));

  elastic_pipeline #(.PIPELINE_STAGES(5), .PIPELINE_WIDTH(8)) dut5 (
    .clk_in(clk), .rst_in(rst), .flush_in(f5), .s_valid_in(sv5), .s_data_in(sd5),
    .s_ready_out(sr5), .m_valid_out(mv5), .m_data_out(md5), .m_ready_in(mr5),
    .count_out(cnt5));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle on dut4: drive after the falling edge, sample 1 time unit later.
  task automatic cyc4(input logic v, input logic [7:0] d, input logic mr, input logic fl);
    @(negedge clk);
    sv4 = v; sd4 = d; mr4 = mr; f4 = fl;
    #1;
    if (mv4 && mr4) begin
      if (exp_q.size() == 0) chk("d4_spurious", 32'(mv4), 32'd0);
      else chk("d4_data", 32'(md4), 32'(exp_q.pop_front()));
    end
    if (sv4 && sr4) exp_q.push_back(sd4);
    if (f4) exp_q.delete();
  endtask

  // One randomised cycle on dut1 (id 1) or dut5 (id 5).
  task automatic rcyc(input int id);
    logic v, mr, fl, sr, mv;
    logic [7:0] d, md;
    int cnt, n, occ;
    v  = ($urandom_range(0, 3) != 0);
    mr = ($urandom_range(0, 1) != 0);
    fl = ($urandom_range(0, 39) == 0);
    d  = 8'($urandom);
    @(negedge clk);
    if (id == 1) begin
      sv1 = v; sd1 = d; mr1 = mr; f1 = fl;
    end else begin
      sv5 = v; sd5 = d; mr5 = mr; f5 = fl;
    end
    #1;
    if (id == 1) begin
      sr = sr1; mv = mv1; md = md1; cnt = int'(cnt1); n = 1;
    end else begin
      sr = sr5; mv = mv5; md = md5; cnt = int'(cnt5); n = 5;
    end
    occ = exp_q.size();
    chk("r_s_ready", 32'(sr), 32'(!fl && (occ < n || mr)));
    chk("r_count", 32'(cnt), 32'(occ));
    if (mv && mr) begin
      if (occ == 0) chk("r_spurious", 32'(mv), 32'd0);
      else chk("r_data", 32'(md), 32'(exp_q.pop_front()));
    end
    if (v && sr) exp_q.push_back(d);
    if (fl) exp_q.delete();
  endtask

  initial begin
    rst = 1'b1;
    {f4, sv4, mr4, f1, sv1, mr1, f5, sv5, mr5} = '0;
    sd4 = '0; sd1 = '0; sd5 = '0;

    // Reset state
    #12;
    chk("rst_m_valid", 32'(mv4), 32'd0);
    chk("rst_count", 32'(cnt4), 32'd0);
    chk("rst_m_data", 32'(md4), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_s_ready", 32'(sr4), 32'd1);

    // Streaming 0x01..0x10 with the consumer always ready
    for (int i = 0; i < 16; i++) begin
      cyc4(1'b1, 8'(i + 1), 1'b1, 1'b0);
      if (i == 3) chk("stream_latency_early", 32'(mv4), 32'd0);
      if (i == 4) chk("stream_first", 32'(md4), 32'h01);
      if (i >= 4) begin
        chk("stream_no_gap", 32'(mv4), 32'd1);
        chk("stream_count", 32'(cnt4), 32'd4);
      end
    end
    for (int i = 0; i < 5; i++) begin
      cyc4(1'b0, 8'h00, 1'b1, 1'b0);
      if (i < 4) chk("stream_drain_no_gap", 32'(mv4), 32'd1);
    end
    chk("stream_all_out", 32'(exp_q.size()), 32'd0);
    chk("stream_count_end", 32'(cnt4), 32'd0);

    // Backpressure: five beats offered into a stalled pipe
    for (int i = 0; i < 5; i++) begin
      cyc4(1'b1, 8'(8'hA0 + i), 1'b0, 1'b0);
      chk("bp_s_ready", 32'(sr4), 32'(i < 4));
    end
    chk("bp_count_full", 32'(cnt4), 32'd4);
    cyc4(1'b1, 8'hA4, 1'b1, 1'b0);
    chk("bp_ready_same_cycle", 32'(sr4), 32'd1);
    for (int i = 0; i < 6; i++) cyc4(1'b0, 8'h00, 1'b1, 1'b0);
    chk("bp_all_out", 32'(exp_q.size()), 32'd0);

    // Bubble collapse toward the output while stalled
    cyc4(1'b1, 8'h11, 1'b0, 1'b0);
    cyc4(1'b0, 8'h00, 1'b0, 1'b0);
    cyc4(1'b0, 8'h00, 1'b0, 1'b0);
    cyc4(1'b1, 8'h22, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc4(1'b0, 8'h00, 1'b0, 1'b0);
    chk("bubble_vld", 32'(dut4.vld), 32'b1100);
    chk("bubble_dat3", 32'(dut4.dat[3]), 32'h11);
    chk("bubble_dat2", 32'(dut4.dat[2]), 32'h22);
    chk("bubble_count", 32'(cnt4), 32'd2);
    for (int i = 0; i < 3; i++) cyc4(1'b0, 8'h00, 1'b1, 1'b0);
    chk("bubble_all_out", 32'(exp_q.size()), 32'd0);

    // Flush with the head beat delivered in the flush cycle
    cyc4(1'b1, 8'hB1, 1'b0, 1'b0);
    cyc4(1'b1, 8'hB2, 1'b0, 1'b0);
    cyc4(1'b1, 8'hB3, 1'b0, 1'b0);
    cyc4(1'b0, 8'h00, 1'b0, 1'b0);
    chk("flush_pre_count", 32'(cnt4), 32'd3);
    cyc4(1'b1, 8'h77, 1'b1, 1'b1);
    chk("flush_s_ready", 32'(sr4), 32'd0);
    chk("flush_head_valid", 32'(mv4), 32'd1);
    cyc4(1'b0, 8'h00, 1'b1, 1'b0);
    chk("flush_m_valid", 32'(mv4), 32'd0);
    chk("flush_count", 32'(cnt4), 32'd0);
    cyc4(1'b1, 8'h5A, 1'b1, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      cyc4(1'b0, 8'h00, 1'b1, 1'b0);
      chk("flush_repush_valid", 32'(mv4), 32'(i == 4));
      if (i == 4) chk("flush_repush_data", 32'(md4), 32'h5A);
    end

    // Asynchronous reset mid-cycle with a beat at the output
    cyc4(1'b1, 8'hC3, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cyc4(1'b0, 8'h00, 1'b0, 1'b0);
    chk("arst_pre_valid", 32'(mv4), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_m_valid", 32'(mv4), 32'd0);
    chk("arst_count", 32'(cnt4), 32'd0);
    chk("arst_m_data", 32'(md4), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    cyc4(1'b0, 8'h00, 1'b0, 1'b0);
    chk("arst_s_ready", 32'(sr4), 32'd1);

    // Random traffic, N = 1 then N = 5
    exp_q.delete();
    for (int i = 0; i < 5000; i++) rcyc(1);
    @(negedge clk);
    {sv1, mr1, f1} = 3'b000;
    exp_q.delete();
    for (int i = 0; i < 5000; i++) rcyc(5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
